// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// Package : median_pkg
// Brief   : Shared pixel width, default frame geometry and helpers.
// Rev     : 1.0 - initial release
// ============================================================================
package median_pkg;

    localparam int c_pix_w      = 8;
    localparam int c_img_width  = 8;
    localparam int c_img_height = 8;

    // Counter/pointer width able to index 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : median_pkg
`default_nettype wire

// File: rtl/line_window_3x3_line_delay.sv
`default_nettype none
// ============================================================================
// Module : line_delay
// Brief  : DEPTH-deep circular store; dout is the sample written DEPTH enables ago.
// Rev    : 1.0 - initial release
// ============================================================================
module line_delay
    import median_pkg::*;
#(
    parameter int DEPTH = c_img_width,
    parameter int PIX_W = c_pix_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int c_ptr_w = idx_w(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

    logic [PIX_W-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + c_ptr_w'(1);
        end
    end

    // Storage is left unreset; contents only reach the window after a full refill.
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= din;
        end
    end

    assign dout = r_mem[r_ptr];

endmodule : line_delay
`default_nettype wire

// File: rtl/line_window_3x3.sv
`default_nettype none
// ============================================================================
// Module : line_window_3x3
// Brief  : Raster stream to 3x3 sliding window with interior-only valid strobe.
// Rev    : 1.0 - initial release
// ============================================================================
module line_window_3x3
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = c_img_width,
    parameter int IMG_HEIGHT = c_img_height,
    parameter int PIX_W      = c_pix_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] win_0,
    output logic [PIX_W-1:0] win_1,
    output logic [PIX_W-1:0] win_2,
    output logic [PIX_W-1:0] win_3,
    output logic [PIX_W-1:0] win_4,
    output logic [PIX_W-1:0] win_5,
    output logic [PIX_W-1:0] win_6,
    output logic [PIX_W-1:0] win_7,
    output logic [PIX_W-1:0] win_8,
    output logic             win_valid
);

    localparam int c_col_w = idx_w(IMG_WIDTH);
    localparam int c_row_w = idx_w(IMG_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [c_col_w-1:0] w_cur_col;
    logic [c_row_w-1:0] w_cur_row;
    logic               w_win_hit;
    logic [PIX_W-1:0]   w_line1;
    logic [PIX_W-1:0]   w_line2;
    logic [PIX_W-1:0]   r_win     [9];
    logic [PIX_W-1:0]   w_win_next[9];
    logic [PIX_W-1:0]   r_win_out [9];
    logic               r_win_valid;

    line_delay #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_line1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_valid),
        .din   (pix_in),
        .dout  (w_line1)
    );

    line_delay #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_line2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_valid),
        .din   (w_line1),
        .dout  (w_line2)
    );

    // sof relocates the accepted pixel to (0,0) regardless of the running counters.
    assign w_cur_col = sof ? '0 : r_col;
    assign w_cur_row = sof ? '0 : r_row;
    assign w_win_hit = (w_cur_row >= c_row_w'(2)) && (w_cur_col >= c_col_w'(2));

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_win_next[3*r]     = r_win[3*r + 1];
            w_win_next[3*r + 1] = r_win[3*r + 2];
        end
        w_win_next[2] = w_line2;
        w_win_next[5] = w_line1;
        w_win_next[8] = pix_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k]     <= '0;
                r_win_out[k] <= '0;
            end
        end else begin
            r_win_valid <= pix_valid && w_win_hit;
            if (pix_valid) begin
                if (w_cur_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (w_cur_row == c_row_last) ? '0 : w_cur_row + c_row_w'(1);
                end else begin
                    r_col <= w_cur_col + c_col_w'(1);
                    r_row <= w_cur_row;
                end
                for (int k = 0; k < 9; k++) begin
                    r_win[k] <= w_win_next[k];
                end
                if (w_win_hit) begin
                    for (int k = 0; k < 9; k++) begin
                        r_win_out[k] <= w_win_next[k];
                    end
                end
            end
        end
    end

    assign win_0     = r_win_out[0];
    assign win_1     = r_win_out[1];
    assign win_2     = r_win_out[2];
    assign win_3     = r_win_out[3];
    assign win_4     = r_win_out[4];
    assign win_5     = r_win_out[5];
    assign win_6     = r_win_out[6];
    assign win_7     = r_win_out[7];
    assign win_8     = r_win_out[8];
    assign win_valid = r_win_valid;

endmodule : line_window_3x3
`default_nettype wire

// File: tb/tb_line_window_3x3.sv
`default_nettype none
// ============================================================================
// Module : tb_line_window_3x3
// Brief  : Self-checking bench: image-model scoreboard plus table of known windows.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_line_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    typedef logic [8:0][7:0] win_t;
    typedef struct packed {
        logic [7:0] base;
        logic [1:0] idx;
        win_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sof, pix_valid;
    logic [7:0] pix_in;
    logic [7:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    logic       win_valid;

    logic       b_sof, b_pix_valid;
    logic [7:0] b_pix_in;
    logic [7:0] bw_0, bw_1, bw_2, bw_3, bw_4, bw_5, bw_6, bw_7, bw_8;
    logic       b_win_valid;

    always #5 clk = ~clk;

    line_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
        .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8), .win_valid(win_valid)
    );

    line_window_3x3 #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sof(b_sof), .pix_valid(b_pix_valid), .pix_in(b_pix_in),
        .win_0(bw_0), .win_1(bw_1), .win_2(bw_2), .win_3(bw_3), .win_4(bw_4),
        .win_5(bw_5), .win_6(bw_6), .win_7(bw_7), .win_8(bw_8), .win_valid(b_win_valid)
    );

    int   checks = 0;
    int   errors = 0;
    win_t exp_q[$];
    win_t obs_q[$];
    win_t last_exp;
    int   m_col, m_row;
    logic [7:0] img [0:H-1][0:W-1];
    vec_t tbl [8];

    function automatic win_t mk9(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic win_t obs_a();
        return {win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1, win_0};
    endfunction

    function automatic win_t obs_b();
        return {bw_8, bw_7, bw_6, bw_5, bw_4, bw_3, bw_2, bw_1, bw_0};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        exp_q.delete();
        obs_q.delete();
        last_exp = '0;
    endtask

    // Reference: place the pixel in a 2D frame image, cut the window from it.
    task automatic model_accept(input logic [7:0] d, input logic s);
        win_t e;
        if (s) begin
            m_col = 0;
            m_row = 0;
        end
        img[m_row][m_col] = d;
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e[3*r + c] = img[m_row - 2 + r][m_col - 2 + c];
            exp_q.push_back(e);
        end
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic observe(input logic acc);
        win_t o;
        win_t e;
        o = obs_a();
        chk("valid_on_idle", 72'(win_valid & ~acc), 72'd0);
        if (win_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: actual %h required none", o);
            end else begin
                e = exp_q.pop_front();
                chk("window", o, e);
                last_exp = e;
            end
            obs_q.push_back(o);
        end else begin
            chk("hold", o, last_exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s);
        pix_valid = v;
        pix_in    = d;
        sof       = s;
        if (v) model_accept(d, s);
        @(posedge clk);
        @(negedge clk);
        observe(v);
    endtask

    task automatic ramp(input logic [7:0] base, input logic toggle, input logic s0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, base + 8'(i), s0 && (i == 0));
            if (toggle) step(1'b0, 8'hEE, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_obs(input string name, input int n_exp,
                             input logic [7:0] base0, input logic [7:0] base1);
        logic [7:0] b;
        chk({name, "_count"}, 72'(obs_q.size()), 72'(n_exp));
        chk({name, "_missing"}, 72'(exp_q.size()), 72'd0);
        for (int i = 0; i < obs_q.size() && i < n_exp; i++) begin
            b = (i < 4) ? base0 : base1;
            for (int k = 0; k < 8; k++)
                if (tbl[k].base == b && tbl[k].idx == 2'(i % 4))
                    chk({name, "_table"}, obs_q[i], tbl[k].exp);
        end
        obs_q.delete();
    endtask

    initial begin
        tbl[0] = '{base: 8'd0, idx: 2'd0, exp: mk9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
        tbl[1] = '{base: 8'd0, idx: 2'd1, exp: mk9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
        tbl[2] = '{base: 8'd0, idx: 2'd2, exp: mk9(4, 5, 6, 8, 9, 10, 12, 13, 14)};
        tbl[3] = '{base: 8'd0, idx: 2'd3, exp: mk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
        for (int k = 0; k < 4; k++) begin
            tbl[k+4].base = 8'd100;
            tbl[k+4].idx  = tbl[k].idx;
            for (int j = 0; j < 9; j++) tbl[k+4].exp[j] = tbl[k].exp[j] + 8'd100;
        end

        rst_n = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
        b_sof = 1'b0; b_pix_valid = 1'b0; b_pix_in = '0;
        model_reset();
        #12;
        chk("reset_win", obs_a(), '0);
        chk("reset_valid", 72'(win_valid), 72'd0);
        chk("reset_win_b", obs_b(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame after reset without sof.
        ramp(8'd0, 1'b0, 1'b0);
        idle(2);
        check_obs("ramp", 4, 8'd0, 8'd0);

        // Alternating valid with sof asserted on idle cycles.
        ramp(8'd0, 1'b1, 1'b1);
        idle(2);
        check_obs("toggle", 4, 8'd0, 8'd0);

        // Back-to-back frames.
        ramp(8'd0, 1'b0, 1'b1);
        ramp(8'd100, 1'b0, 1'b1);
        idle(2);
        check_obs("b2b", 8, 8'd0, 8'd100);

        // Restart mid-frame via sof.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(i), i == 0);
        ramp(8'd0, 1'b0, 1'b1);
        idle(2);
        check_obs("sof_restart", 4, 8'd0, 8'd0);

        // Asynchronous reset mid-frame after pixel 9.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), i == 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_win", obs_a(), '0);
        chk("midreset_valid", 72'(win_valid), 72'd0);
        idle(2);
        rst_n = 1'b1;
        ramp(8'd0, 1'b0, 1'b0);
        idle(2);
        check_obs("after_reset", 4, 8'd0, 8'd0);

        // Minimum 3x3 frame on the second instance.
        for (int i = 1; i <= 9; i++) begin
            b_pix_valid = 1'b1;
            b_pix_in    = 8'(i);
            b_sof       = (i == 1);
            @(posedge clk);
            @(negedge clk);
            chk("b_valid", 72'(b_win_valid), 72'(i == 9));
        end
        b_pix_valid = 1'b0;
        b_sof       = 1'b0;
        chk("b_window", obs_b(), mk9(1, 2, 3, 4, 5, 6, 7, 8, 9));
        chk("b_centre", 72'(bw_4), 72'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b_idle_valid", 72'(b_win_valid), 72'd0);
            chk("b_hold", obs_b(), mk9(1, 2, 3, 4, 5, 6, 7, 8, 9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_line_window_3x3
`default_nettype wire

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 The block SHALL take parameter IMG_WIDTH, default 8: pixels per line, legal range 3..1024.
REQ-002 The block SHALL take parameter IMG_HEIGHT, default 8: lines per frame, legal range 3..1024.
REQ-003 The block SHALL take parameter PIX_W, default 8: bits per pixel.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 sof  input  1  start-of-frame; qualifies the pixel presented with pix_valid as pixel (0,0).
REQ-007 pix_valid  input  1  pix_in is valid this cycle; a pixel is accepted on every cycle with pix_valid=1, with no backpressure.
REQ-008 pix_in  input  PIX_W  raster-order pixel, left to right, top to bottom.
REQ-009 win_0..win_8  output  PIX_W each  3x3 window in row-major order: win_0 is top-left, win_4 is the centre, win_8 is bottom-right; these ports feed in_0..in_8 of the median filter.
REQ-010 win_valid  output  1  one-cycle strobe; the window is complete; drives the median filter's enable.

Function
REQ-011 The block SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), both advancing only on an accepted pixel.
REQ-012 col SHALL wrap from IMG_WIDTH-1 to 0 and then increment row; row SHALL wrap from IMG_HEIGHT-1 to 0 after the last pixel of the frame.
REQ-013 An accepted pixel with sof=1 SHALL be taken as (0,0): counters are forced so the next pixel is (0,1); this overrides any position mid-frame.
REQ-014 sof with pix_valid=0 SHALL be ignored.
REQ-015 The block SHALL hold two line stores of IMG_WIDTH x PIX_W, delaying the stream by exactly one line and two lines.
REQ-016 The block SHALL hold a 3x3 register window, shifted left by one column on every accepted pixel.
REQ-017 The new right column SHALL be {line-2 delayed, line-1 delayed, pix_in}, top to bottom.
REQ-018 win_valid SHALL assert for exactly one cycle, in the cycle after accepting the pixel at (row, col) with row>=2 and col>=2.
REQ-019 When win_valid asserts, win_0..win_8 SHALL hold rows row-2..row by columns col-2..col.
REQ-020 Border pixels SHALL produce no window: no padding, giving (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-021 Window registers crossing a line wrap SHALL NOT produce a window until two new pixels of the current line have entered.
REQ-022 win_0..win_8 SHALL hold their value while win_valid=0.
REQ-023 Idle cycles (pix_valid=0) SHALL change no state and SHALL hold win_valid at 0.
REQ-024 Throughput SHALL be one pixel per cycle; the block SHALL NOT stall.
REQ-025 Line-store contents SHALL NOT be cleared by sof; stale data is never exposed because of REQ-018.

Reset
REQ-026 On rst_n=0, col, row, the window registers, win_0..win_8 and win_valid SHALL all become 0 asynchronously.
REQ-027 Line-store contents SHALL be don't-care after reset.
REQ-028 The first accepted pixel after reset SHALL be taken as (0,0), whether or not sof is set.
REQ-029 Reset mid-frame SHALL abandon the frame with no further win_valid until a fresh 2-line, 3-pixel fill.

Structure
REQ-030 Shared package median_pkg SHALL hold PIX_W, default IMG_WIDTH and default IMG_HEIGHT, and SHALL be reused by the median filter and top level.
REQ-031 Sub-module line_delay SHALL be a parameterised IMG_WIDTH-deep, PIX_W-wide shift/circular store with an enable input, instantiated twice and cascaded.
REQ-032 Counters, the window register and valid generation SHALL live in line_window_3x3.

Verification
REQ-033 Ramp frame: W=4, H=4, pixels 0..15 with continuous valid -> 4 win_valid pulses; the first window is 0,1,2,4,5,6,8,9,10 one cycle after pixel 10; the last window is 5,6,7,9,10,11,13,14,15.
REQ-034 Same ramp with pix_valid toggling 1,0,1,0 -> identical windows and count; win_valid never asserts on an idle cycle; outputs hold between pulses.
REQ-035 Two back-to-back frames (second ramp 100..115, sof on pixel 100) -> 8 pulses total; the first window of frame 2 is 100,101,102,104,105,106,108,109,110, with no frame-1 data leaking in.
REQ-036 sof asserted at pixel 6 of frame 1, then ramp 0..15 -> the block restarts; windows match REQ-033 exactly.
REQ-037 rst_n pulsed low after pixel 9 -> outputs 0 immediately; the next 16-pixel ramp yields the REQ-033 windows.
REQ-038 W=3, H=3, pixels 1..9 -> exactly one pulse with window 1..9 and win_4=5, fed to the median filter.
